// File: rtl/sd_pixel_packer_if.sv
// Byte-stream-in / RAM-write-out bundle for sd_pixel_packer.
// master = the packer (consumes bytes, drives the RAM port); slave = its environment.
interface sd_pixel_packer_if #(
  parameter int ADDR_W = 17
);
  logic [7:0]        data_in;
  logic              data_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_data;
  logic              ram_write_en;

  modport master (
    input  data_in,
    input  data_valid,
    output ram_addr,
    output ram_data,
    output ram_write_en
  );

  modport slave (
    output data_in,
    output data_valid,
    input  ram_addr,
    input  ram_data,
    input  ram_write_en
  );
endinterface

// File: rtl/sd_pixel_packer.sv
// Drops a fixed image header from the SD byte stream and packs byte pairs into 16-bit
// RAM writes at slot*IMAGE_WORDS + n. Define PACKER_SWAP_BYTES_EN to put the first byte in [7:0].
module sd_pixel_packer #(
  parameter int ADDR_W       = 17,
  parameter int IMAGE_WORDS  = 19200,
  parameter int HEADER_BYTES = 4,
  parameter int CNT_W        = 15
) (
  input  logic             clk_100MHz,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       slot,
  sd_pixel_packer_if.master bus,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [CNT_W-1:0] word_count
);

  localparam int HDR_W = (HEADER_BYTES < 2) ? 1 : $clog2(HEADER_BYTES);
  localparam logic [HDR_W-1:0]  HDR_LAST    = HDR_W'((HEADER_BYTES == 0) ? 0 : HEADER_BYTES - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD   = CNT_W'(IMAGE_WORDS - 1);
  localparam logic [ADDR_W-1:0] IMG_WORDS_A = ADDR_W'(IMAGE_WORDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_LO,
    S_HI,
    S_DONE
  } state_t;

  state_t            state_reg, state_next;
  logic [HDR_W-1:0]  hdr_cnt_reg, hdr_cnt_next;
  logic [7:0]        first_byte_reg, first_byte_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [CNT_W-1:0]  word_count_reg, word_count_next;
  logic              done_reg, done_next;
  logic              overflow_reg, overflow_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic [15:0]       ram_data_reg, ram_data_next;
  logic              ram_we_reg, ram_we_next;

  logic [ADDR_W-1:0] slot_base;
  logic [15:0]       packed_word;

  assign slot_base = ADDR_W'(slot) * IMG_WORDS_A;

`ifdef PACKER_SWAP_BYTES_EN
  assign packed_word = {bus.data_in, first_byte_reg};
`else
  assign packed_word = {first_byte_reg, bus.data_in};
`endif

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // start outranks a byte arriving in the same cycle; that byte is simply lost.
  always_comb begin
    state_next      = state_reg;
    hdr_cnt_next    = hdr_cnt_reg;
    first_byte_next = first_byte_reg;
    base_next       = base_reg;
    word_count_next = word_count_reg;
    done_next       = done_reg;
    overflow_next   = overflow_reg;
    ram_addr_next   = ram_addr_reg;
    ram_data_next   = ram_data_reg;
    ram_we_next     = 1'b0;

    if (start) begin
      base_next       = slot_base;
      word_count_next = '0;
      done_next       = 1'b0;
      overflow_next   = 1'b0;
      first_byte_next = '0;
      hdr_cnt_next    = '0;
      state_next      = (HEADER_BYTES == 0) ? S_LO : S_HEADER;
    end else if (bus.data_valid) begin
      case (state_reg)
        S_IDLE: begin
          state_next = S_IDLE;
        end
        S_HEADER: begin
          if (hdr_cnt_reg == HDR_LAST) begin
            hdr_cnt_next = '0;
            state_next   = S_LO;
          end else begin
            hdr_cnt_next = hdr_cnt_reg + HDR_W'(1);
          end
        end
        S_LO: begin
          first_byte_next = bus.data_in;
          state_next      = S_HI;
        end
        S_HI: begin
          ram_we_next     = 1'b1;
          ram_addr_next   = base_reg + ADDR_W'(word_count_reg);
          ram_data_next   = packed_word;
          word_count_next = word_count_reg + CNT_W'(1);
          if (word_count_reg == LAST_WORD) begin
            done_next  = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_LO;
          end
        end
        S_DONE: begin
          overflow_next = 1'b1;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      hdr_cnt_reg    <= '0;
      first_byte_reg <= '0;
      base_reg       <= '0;
      word_count_reg <= '0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
      ram_addr_reg   <= '0;
      ram_data_reg   <= '0;
      ram_we_reg     <= 1'b0;
    end else begin
      hdr_cnt_reg    <= hdr_cnt_next;
      first_byte_reg <= first_byte_next;
      base_reg       <= base_next;
      word_count_reg <= word_count_next;
      done_reg       <= done_next;
      overflow_reg   <= overflow_next;
      ram_addr_reg   <= ram_addr_next;
      ram_data_reg   <= ram_data_next;
      ram_we_reg     <= ram_we_next;
    end
  end

  assign busy             = (state_reg == S_HEADER) || (state_reg == S_LO) || (state_reg == S_HI);
  assign done             = done_reg;
  assign overflow         = overflow_reg;
  assign word_count       = word_count_reg;
  assign bus.ram_addr     = ram_addr_reg;
  assign bus.ram_data     = ram_data_reg;
  assign bus.ram_write_en = ram_we_reg;

endmodule

// File: tb/tb_sd_pixel_packer.sv
// Scoreboard bench for sd_pixel_packer: stimulus queues expected RAM writes,
// a negedge monitor pops and compares each strobe.
`timescale 1ns/1ps
module tb_sd_pixel_packer;
  localparam int ADDR_W       = 17;
  localparam int IMAGE_WORDS  = 19200;
  localparam int HEADER_BYTES = 4;
  localparam int CNT_W        = 15;

`ifdef PACKER_SWAP_BYTES_EN
  localparam logic [15:0] BASIC_EXP   = 16'hCDAB;
  localparam logic [15:0] RESTART_EXP = 16'h3322;
  localparam logic [15:0] REVIVE_EXP  = 16'h3412;
`else
  localparam logic [15:0] BASIC_EXP   = 16'hABCD;
  localparam logic [15:0] RESTART_EXP = 16'h2233;
  localparam logic [15:0] REVIVE_EXP  = 16'h1234;
`endif

  logic             clk_100MHz = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       slot = 2'd0;
  logic             busy, done, overflow;
  logic [CNT_W-1:0] word_count;

  sd_pixel_packer_if #(.ADDR_W(ADDR_W)) bus ();

  sd_pixel_packer #(
    .ADDR_W(ADDR_W),
    .IMAGE_WORDS(IMAGE_WORDS),
    .HEADER_BYTES(HEADER_BYTES),
    .CNT_W(CNT_W)
  ) dut (
    .clk_100MHz(clk_100MHz),
    .rst(rst),
    .start(start),
    .slot(slot),
    .bus(bus.master),
    .busy(busy),
    .done(done),
    .overflow(overflow),
    .word_count(word_count)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
    logic [CNT_W-1:0]  wc;
    logic              done;
  } exp_t;

  exp_t exp_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_compared++;
    if (act !== req) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] pack(input logic [7:0] b0, input logic [7:0] b1);
`ifdef PACKER_SWAP_BYTES_EN
    return {b1, b0};
`else
    return {b0, b1};
`endif
  endfunction

  task automatic push(input int addr, input logic [15:0] data, input int wc, input logic dn);
    exp_t e;
    e.addr = ADDR_W'(addr);
    e.data = data;
    e.wc   = CNT_W'(wc);
    e.done = dn;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    step();
    bus.data_valid = 1'b0;
    repeat (gap) step();
  endtask

  task automatic do_start(input logic [1:0] s);
    slot  = s;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic header();
    for (int h = 0; h < HEADER_BYTES; h++) send(8'hF0 + 8'(h), h % 2);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_addr"}, 32'(bus.ram_addr), 0);
    check({tag, "_ram_data"}, 32'(bus.ram_data), 0);
    check({tag, "_ram_write_en"}, 32'(bus.ram_write_en), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_word_count"}, 32'(word_count), 0);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100MHz);
      if (bus.ram_write_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("FAIL unexpected_write: addr=%0d data=0x%04h, required no write",
                   bus.ram_addr, bus.ram_data);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
          check("wr_data", 32'(bus.ram_data), 32'(e.data));
          check("wr_word_count", 32'(word_count), 32'(e.wc));
          check("wr_done", 32'(done), 32'(e.done));
          $display("write addr=%0d data=0x%04h word_count=%0d done=%0b",
                   bus.ram_addr, bus.ram_data, word_count, done);
        end
      end
    end
  end

  initial begin
    logic [7:0] b0, b1;
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;
    #2 rst = 1'b1;
    repeat (3) step();
    check_all_zero("reset");
    rst = 1'b0;
    step();

    // Basic load, slot 0
    do_start(2'd0);
    check("basic_busy_after_start", 32'(busy), 1);
    header();
    push(0, BASIC_EXP, 1, 1'b0);
    send(8'hAB, 0);
    send(8'hCD, 0);
    check("basic_word_count", 32'(word_count), 1);
    check("basic_busy", 32'(busy), 1);
    repeat (3) step();
    check("basic_hold_addr", 32'(bus.ram_addr), 0);
    check("basic_hold_data", 32'(bus.ram_data), 32'(BASIC_EXP));

    // Full image, slot 2, with occasional idle gaps of 0..3 cycles
    do_start(2'd2);
    check("full_wc_cleared", 32'(word_count), 0);
    header();
    for (int i = 0; i < IMAGE_WORDS; i++) begin
      b0 = 8'(i);
      b1 = 8'(i >> 8) ^ 8'h5A;
      push(38400 + i, pack(b0, b1), i + 1, (i == IMAGE_WORDS - 1));
      send(b0, (i % 16 == 5) ? 1 : 0);
      send(b1, (i % 8 == 7) ? (i / 8) % 4 : 0);
    end
    step();
    check("full_done", 32'(done), 1);
    check("full_busy", 32'(busy), 0);
    check("full_word_count", 32'(word_count), IMAGE_WORDS);
    check("full_overflow_before", 32'(overflow), 0);

    // Overrun: extra bytes while DONE
    send(8'h77, 1);
    send(8'h88, 0);
    send(8'h99, 2);
    check("overrun_overflow", 32'(overflow), 1);
    check("overrun_done", 32'(done), 1);
    check("overrun_word_count", 32'(word_count), IMAGE_WORDS);

    // Restart mid-word; the byte coincident with start is dropped
    do_start(2'd1);
    check("restart_overflow_cleared", 32'(overflow), 0);
    check("restart_done_cleared", 32'(done), 0);
    header();
    send(8'h11, 0);
    slot           = 2'd3;
    start          = 1'b1;
    bus.data_in    = 8'h99;
    bus.data_valid = 1'b1;
    step();
    start          = 1'b0;
    bus.data_valid = 1'b0;
    header();
    push(57600, RESTART_EXP, 1, 1'b0);
    send(8'h22, 0);
    send(8'h33, 0);
    check("restart_word_count", 32'(word_count), 1);
    step();

    // Reset mid-load after 100 words
    do_start(2'd0);
    header();
    for (int i = 0; i < 100; i++) begin
      b0 = 8'(i * 3);
      b1 = 8'(i) ^ 8'hC3;
      push(i, pack(b0, b1), i + 1, 1'b0);
      send(b0, 0);
      send(b1, 0);
    end
    send(8'hEE, 1);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    repeat (2) step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) send(8'h40 + 8'(i), i % 2);
    check("postrst_word_count", 32'(word_count), 0);
    check("postrst_busy", 32'(busy), 0);
    do_start(2'd0);
    header();
    push(0, REVIVE_EXP, 1, 1'b0);
    send(8'h12, 0);
    send(8'h34, 0);
    repeat (3) step();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
